// File: rtl/module_teclado_scan.sv
// module_teclado_scan: 4x4 matrix keypad scanner with press/release debounce.
// Drives one active-low column at a time and samples the synchronized rows.
// Each accepted press yields column/row index codes and a one-cycle active-low
// ready strobe for the downstream digit decoder.
module module_teclado_scan #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] filas_i,
    output logic [3:0] columnas_o,
    output logic [1:0] dato_codc_o,
    output logic [1:0] dato_codf_o,
    output logic       dato_listo_o
);

    localparam int SCAN_W = $clog2(SCAN_DIV) + 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] S_SCAN      = 3'd0;
    localparam logic [2:0] S_DEB_PRESS = 3'd1;
    localparam logic [2:0] S_REPORT    = 3'd2;
    localparam logic [2:0] S_HOLD      = 3'd3;
    localparam logic [2:0] S_DEB_REL   = 3'd4;

    logic [2:0]        state;
    logic [1:0]        col;
    logic [1:0]        cand_row;
    logic [SCAN_W-1:0] scan_cnt;
    logic [DEB_W-1:0]  deb_cnt;
    logic [3:0]        filas_m;
    logic [3:0]        filas_s;
    logic [1:0]        low_idx;
    logic              any_low;
    logic              all_high;

    assign columnas_o = ~(4'b0001 << col);
    assign any_low    = ~(&filas_s);
    assign all_high   = &filas_s;

    // Lowest-index closed row wins when several rows read low together.
    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!filas_s[i]) begin
                low_idx = 2'(i);
            end
        end
    end

    // Two-flop synchronizer; idle keypad rows read high, so reset to all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filas_m <= 4'b1111;
            filas_s <= 4'b1111;
        end else begin
            filas_m <= filas_i;
            filas_s <= filas_m;
        end
    end

    // Scan / debounce / hold sequencer; also owns the column and candidate row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_SCAN;
            col      <= 2'd0;
            cand_row <= 2'd0;
            scan_cnt <= '0;
            deb_cnt  <= '0;
        end else begin
            case (state)
                S_SCAN: begin
                    if (scan_cnt == SCAN_LAST) begin
                        scan_cnt <= '0;
                        if (any_low) begin
                            cand_row <= low_idx;
                            deb_cnt  <= '0;
                            state    <= S_DEB_PRESS;
                        end else begin
                            col <= col + 2'd1;
                        end
                    end else begin
                        scan_cnt <= scan_cnt + SCAN_W'(1);
                    end
                end
                S_DEB_PRESS: begin
                    if (filas_s[cand_row]) begin
                        deb_cnt  <= '0;
                        scan_cnt <= '0;
                        state    <= S_SCAN;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt <= '0;
                        state   <= S_REPORT;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                S_REPORT: begin
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    if (all_high) begin
                        deb_cnt <= '0;
                        state   <= S_DEB_REL;
                    end
                end
                S_DEB_REL: begin
                    if (!all_high) begin
                        deb_cnt <= '0;
                        state   <= S_HOLD;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt  <= '0;
                        scan_cnt <= '0;
                        col      <= col + 2'd1;
                        state    <= S_SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                default: begin
                    deb_cnt  <= '0;
                    scan_cnt <= '0;
                    state    <= S_SCAN;
                end
            endcase
        end
    end

    // Codes and strobe are registered so they change together the cycle after REPORT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dato_codc_o  <= 2'd0;
            dato_codf_o  <= 2'd0;
            dato_listo_o <= 1'b1;
        end else begin
            dato_listo_o <= (state != S_REPORT);
            if (state == S_REPORT) begin
                dato_codc_o <= col;
                dato_codf_o <= cand_row;
            end
        end
    end

endmodule

// File: tb/tb_module_teclado_scan.sv
// tb_module_teclado_scan: keypad-model bench with a scoreboard of expected key codes.
module tb_module_teclado_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] filas_i;
    logic [3:0] columnas_o;
    logic [1:0] dato_codc_o;
    logic [1:0] dato_codf_o;
    logic       dato_listo_o;

    typedef struct {
        logic [1:0] c;
        logic [1:0] r;
    } exp_t;

    exp_t sb[$];

    logic [3:0] keys [4];
    int n_cmp = 0;
    int n_bad = 0;
    int strobe_count = 0;
    int strobe_long  = 0;
    logic prev_low = 1'b0;

    module_teclado_scan #(
        .SCAN_DIV(4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .filas_i(filas_i),
        .columnas_o(columnas_o),
        .dato_codc_o(dato_codc_o),
        .dato_codf_o(dato_codf_o),
        .dato_listo_o(dato_listo_o)
    );

    always #5 clk = ~clk;

    // Keypad model: a closed key pulls its row low while its column is driven.
    always_comb begin
        filas_i = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            if (!columnas_o[c]) begin
                filas_i = filas_i & ~keys[c];
            end
        end
    end

    // Strobe monitor: counts strobe cycles and flags any strobe wider than one cycle.
    always @(posedge clk) begin
        if (dato_listo_o === 1'b0) begin
            strobe_count <= strobe_count + 1;
            if (prev_low) strobe_long <= strobe_long + 1;
            prev_low <= 1'b1;
        end else begin
            prev_low <= 1'b0;
        end
    end

    task automatic clear_keys();
        for (int c = 0; c < 4; c++) keys[c] = 4'b0000;
    endtask

    task automatic wait_strobe(input int budget, output int k);
        k = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (dato_listo_o === 1'b0) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic release_and_idle();
        clear_keys();
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset();
        clear_keys();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (columnas_o !== 4'b1110 || dato_codc_o !== 2'd0 || dato_codf_o !== 2'd0 || dato_listo_o !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL reset_values: got col=%b c=%0d r=%0d rdy=%b, want 1110/0/0/1",
                     columnas_o, dato_codc_o, dato_codf_o, dato_listo_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp_col;
        for (int i = 0; i < 20; i++) begin
            exp_col = ~(4'b0001 << ((i / 4) % 4));
            n_cmp++;
            if (columnas_o !== exp_col || dato_listo_o !== 1'b1 || dato_codc_o !== 2'd0 || dato_codf_o !== 2'd0) begin
                n_bad++;
                $display("[TB] FAIL idle_scan[%0d]: got col=%b rdy=%b c=%0d r=%0d, want col=%b rdy=1 c=0 r=0",
                         i, columnas_o, dato_listo_o, dato_codc_o, dato_codf_o, exp_col);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single_press();
        int k;
        int base;
        exp_t e;
        keys[0][2] = 1'b1;
        sb.push_back('{c: 2'd0, r: 2'd2});
        wait_strobe(100, k);
        n_cmp++;
        if (k < 0) begin
            n_bad++;
            $display("[TB] FAIL press_timeout: got no strobe, want strobe for 0/2");
        end else begin
            e = sb.pop_front();
            if (dato_codc_o !== e.c || dato_codf_o !== e.r || columnas_o !== 4'b1110) begin
                n_bad++;
                $display("[TB] FAIL press_codes: got c=%0d r=%0d col=%b, want c=%0d r=%0d col=1110",
                         dato_codc_o, dato_codf_o, columnas_o, e.c, e.r);
            end
        end
        @(negedge clk);
        base = strobe_count;
        repeat (50) @(negedge clk);
        n_cmp++;
        if (strobe_count !== base) begin
            n_bad++;
            $display("[TB] FAIL no_repeat: got %0d extra strobes, want 0", strobe_count - base);
        end
        keys[0][2] = 1'b0;
        k = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (columnas_o !== 4'b1110) begin
                k = i;
                break;
            end
        end
        n_cmp++;
        if (k != 11 || columnas_o !== 4'b1101) begin
            n_bad++;
            $display("[TB] FAIL release_resume: got col=%b after %0d cycles, want 1101 after 11", columnas_o, k);
        end
    endtask

    task automatic test_bounce();
        int k;
        int base;
        exp_t e;
        base = strobe_count;
        for (int i = 0; i < 40; i++) begin
            keys[3][1] = (((i / 3) % 2) == 0);
            @(negedge clk);
        end
        n_cmp++;
        if (strobe_count !== base) begin
            n_bad++;
            $display("[TB] FAIL bounce_quiet: got %0d strobes during bounce, want 0", strobe_count - base);
        end
        keys[3][1] = 1'b1;
        sb.push_back('{c: 2'd3, r: 2'd1});
        wait_strobe(100, k);
        n_cmp++;
        if (k < 0) begin
            n_bad++;
            $display("[TB] FAIL bounce_timeout: got no strobe, want strobe for 3/1");
        end else begin
            e = sb.pop_front();
            if (dato_codc_o !== e.c || dato_codf_o !== e.r) begin
                n_bad++;
                $display("[TB] FAIL bounce_codes: got c=%0d r=%0d, want c=%0d r=%0d",
                         dato_codc_o, dato_codf_o, e.c, e.r);
            end
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (strobe_count - base !== 1) begin
            n_bad++;
            $display("[TB] FAIL bounce_once: got %0d strobes, want 1", strobe_count - base);
        end
        release_and_idle();
    endtask

    task automatic test_priority();
        int k;
        exp_t e;
        keys[1][0] = 1'b1;
        keys[1][3] = 1'b1;
        sb.push_back('{c: 2'd1, r: 2'd0});
        wait_strobe(100, k);
        n_cmp++;
        if (k < 0) begin
            n_bad++;
            $display("[TB] FAIL prio_timeout: got no strobe, want strobe for 1/0");
        end else begin
            e = sb.pop_front();
            if (dato_codc_o !== e.c || dato_codf_o !== e.r) begin
                n_bad++;
                $display("[TB] FAIL prio_codes: got c=%0d r=%0d, want c=%0d r=%0d",
                         dato_codc_o, dato_codf_o, e.c, e.r);
            end
        end
        release_and_idle();
    endtask

    task automatic test_reset_mid();
        int k;
        int base;
        exp_t e;
        for (int i = 0; i < 40 && columnas_o === 4'b1011; i++) @(negedge clk);
        for (int i = 0; i < 40 && columnas_o !== 4'b1011; i++) @(negedge clk);
        keys[2][1] = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (columnas_o !== 4'b1110 || dato_codc_o !== 2'd0 || dato_codf_o !== 2'd0 || dato_listo_o !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL rst_deb_press: got col=%b c=%0d r=%0d rdy=%b, want 1110/0/0/1",
                     columnas_o, dato_codc_o, dato_codf_o, dato_listo_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.push_back('{c: 2'd2, r: 2'd1});
        wait_strobe(100, k);
        n_cmp++;
        if (k != 21) begin
            n_bad++;
            $display("[TB] FAIL rst_redebounce1: got strobe after %0d cycles, want 21", k);
        end
        if (k >= 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (dato_codc_o !== e.c || dato_codf_o !== e.r) begin
                n_bad++;
                $display("[TB] FAIL rst_codes1: got c=%0d r=%0d, want c=%0d r=%0d",
                         dato_codc_o, dato_codf_o, e.c, e.r);
            end
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (columnas_o !== 4'b1110 || dato_codc_o !== 2'd0 || dato_codf_o !== 2'd0 || dato_listo_o !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL rst_strobe: got col=%b c=%0d r=%0d rdy=%b, want 1110/0/0/1",
                     columnas_o, dato_codc_o, dato_codf_o, dato_listo_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = strobe_count;
        sb.push_back('{c: 2'd2, r: 2'd1});
        wait_strobe(100, k);
        n_cmp++;
        if (k != 21) begin
            n_bad++;
            $display("[TB] FAIL rst_redebounce2: got strobe after %0d cycles, want 21", k);
        end
        if (k >= 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (dato_codc_o !== e.c || dato_codf_o !== e.r) begin
                n_bad++;
                $display("[TB] FAIL rst_codes2: got c=%0d r=%0d, want c=%0d r=%0d",
                         dato_codc_o, dato_codf_o, e.c, e.r);
            end
        end
        repeat (30) @(negedge clk);
        n_cmp++;
        if (strobe_count - base !== 1) begin
            n_bad++;
            $display("[TB] FAIL rst_once: got %0d strobes, want 1", strobe_count - base);
        end
        release_and_idle();
    endtask

    task automatic test_back_to_back();
        int k;
        int bad_hold;
        exp_t e;
        keys[1][3] = 1'b1;
        sb.push_back('{c: 2'd1, r: 2'd3});
        wait_strobe(100, k);
        n_cmp++;
        if (k < 0) begin
            n_bad++;
            $display("[TB] FAIL b2b_timeout1: got no strobe, want strobe for 1/3");
        end else begin
            e = sb.pop_front();
            if (dato_codc_o !== e.c || dato_codf_o !== e.r) begin
                n_bad++;
                $display("[TB] FAIL b2b_codes1: got c=%0d r=%0d, want c=%0d r=%0d",
                         dato_codc_o, dato_codf_o, e.c, e.r);
            end
        end
        repeat (5) @(negedge clk);
        keys[1][3] = 1'b0;
        bad_hold = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dato_codc_o !== 2'd1 || dato_codf_o !== 2'd3 || dato_listo_o !== 1'b1) bad_hold++;
        end
        n_cmp++;
        if (bad_hold != 0) begin
            n_bad++;
            $display("[TB] FAIL b2b_hold: got %0d cycles deviating, want codes 1/3 rdy=1 throughout", bad_hold);
        end
        keys[3][0] = 1'b1;
        sb.push_back('{c: 2'd3, r: 2'd0});
        wait_strobe(100, k);
        n_cmp++;
        if (k < 0) begin
            n_bad++;
            $display("[TB] FAIL b2b_timeout2: got no strobe, want strobe for 3/0");
        end else begin
            e = sb.pop_front();
            if (dato_codc_o !== e.c || dato_codf_o !== e.r) begin
                n_bad++;
                $display("[TB] FAIL b2b_codes2: got c=%0d r=%0d, want c=%0d r=%0d",
                         dato_codc_o, dato_codf_o, e.c, e.r);
            end
        end
        release_and_idle();
    endtask

    task automatic test_final();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        n_cmp++;
        if (strobe_long != 0) begin
            n_bad++;
            $display("[TB] FAIL strobe_width: got %0d over-long strobes, want 0", strobe_long);
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_single_press();
        test_bounce();
        test_priority();
        test_reset_mid();
        test_back_to_back();
        test_final();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, want bench to finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/module_teclado_scan.md
Name: module_teclado_scan

Overview:
Scanner and encoder for the 4x4 matrix keypad; the producer side of the keypad digit decoder. It drives the keypad columns one at a time and samples the rows. It debounces press and release. For each accepted press it emits the column and row index codes plus an active-low ready strobe. The codes feed the decoder's column/row code inputs directly, and the strobe feeds its ready input.

Parameters:
SCAN_DIV, 1000, clock cycles each column stays driven before rows are sampled (minimum 3, covers synchronizer latency)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press or a release (minimum 1)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
filas_i  input  4  keypad rows, active-low (pulled up; low = key closed on driven column)
columnas_o  output  4  column drive, active-low, exactly one bit low at all times
dato_codc_o  output  2  column index of last accepted key
dato_codf_o  output  2  row index of last accepted key
dato_listo_o  output  1  active-low strobe, low for exactly 1 cycle per accepted press

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous, active-high; every flop clears on rst assertion.
- Reset values:
  - columnas_o = 4'b1110 (column 0 driven)
  - dato_codc_o = 0, dato_codf_o = 0
  - dato_listo_o = 1
  - state = SCAN, all counters 0, synchronizer flops = 4'b1111
- Row input: filas_i passes through a 2-FF synchronizer; only the synchronized value (filas_s) is used. No combinational path from filas_i to any output.
- Column drive: columnas_o = ~(4'b0001 << col). col is a 2-bit register.
- SCAN state:
  - Count SCAN_DIV cycles with col held. On the last count, sample filas_s.
  - If any bit is low: latch cand_row = lowest-index low bit (row 0 has priority on multiple presses), clear the debounce counter, go to DEB_PRESS. col is unchanged.
  - Else: col <= col+1, wrapping 3 -> 0; the scan counter restarts.
- DEB_PRESS state:
  - col stays driven. Each cycle filas_s[cand_row] == 0 increments the counter.
  - Any cycle it reads 1: go to SCAN, counter cleared, same col, full SCAN_DIV wait.
  - Counter reaching DEBOUNCE_CYCLES: go to REPORT.
- REPORT state, one cycle:
  - dato_codc_o <= col, dato_codf_o <= cand_row.
  - dato_listo_o is low during the cycle after REPORT, i.e. registered, and asserted together with the new codes.
  - Next state HOLD.
- HOLD state:
  - Wait while filas_s != 4'b1111, with col still driven.
  - All-high: clear counter, go to DEB_REL.
- DEB_REL state:
  - Count consecutive all-high cycles. Any low bit returns to HOLD.
  - Reaching DEBOUNCE_CYCLES: col <= col+1 (wrap), go to SCAN.
- Output stability: codes change only on an accepted press and hold their value indefinitely otherwise. dato_listo_o is high in every cycle except the strobe cycle.
- Repeats: a held key produces exactly one strobe; no auto-repeat. A second key pressed while the first is held is ignored until full release.
- Counter widths: $clog2 of the respective parameter + 1. No overflow is possible because each counter clears on its terminal count.
- Reset mid-operation (any state, including the strobe cycle): outputs return immediately to reset values. No strobe is emitted after reset deasserts until a full new press is debounced.

Test Plan:
Use SCAN_DIV=4 and DEBOUNCE_CYCLES=8 for all scenarios.
1. Reset, then idle with filas_i=4'b1111 -> columnas_o cycles 1110, 1101, 1011, 0111, 1110 with 4 cycles each; dato_listo_o stays 1; codes stay 0.
2. Hold row 2 low only while column 0 is driven, kept pressed -> after scan + 8 stable cycles, one 1-cycle dato_listo_o=0 with dato_codc_o=0, dato_codf_o=2 (decoder yields 7). No further strobe while held. After release plus 8 high cycles, scanning resumes at column 1.
3. Bounce: row 1 on column 3 toggles low/high every 3 cycles for 40 cycles, then steady low -> no strobe during bounce. Exactly one strobe with codc=3, codf=1 after 8 steady cycles.
4. Rows 0 and 3 both low on column 1 -> strobe with codc=1, codf=0 (lowest-row priority).
5. Assert rst during DEB_PRESS and again on the strobe cycle -> outputs immediately 1110/0/0/1. The key held through reset produces exactly one strobe after a full new debounce.
6. Press column 1 row 3, release, then press column 3 row 0 -> two strobes, codes 1/3 then 3/0. Codes hold 1/3 between the strobes.
